// File: rtl/fifosync.sv
// Single-clock synchronous FIFO with occupancy count, programmable almost-full/
// almost-empty thresholds, sticky overflow/underflow flags and optional FWFT read.
module fifosync #(
    parameter int DW       = 16,
    parameter int AW       = 4,
    parameter int AF_LEVEL = (1 << AW) - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    output logic          full,
    output logic          almost_full,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);
    localparam int          DEPTH  = 1 << AW;
    localparam logic [AW:0] AF_THR = AF_LEVEL[AW:0];
    localparam logic [AW:0] AE_THR = AE_LEVEL[AW:0];

    logic [DW-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_acc, rd_acc;

    // Flags look only at registered pointers, so request inputs never reach them.
    assign full         = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign count        = wr_ptr_q - rd_ptr_q;
    assign almost_full  = (count >= AF_THR);
    assign almost_empty = (count <= AE_THR);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        overflow_d  = overflow_q | (wr_en & full);
        underflow_d = underflow_q | (rd_en & empty);
        if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; zeroed pointers make stale
    // contents unreachable, and leaving it reset-free keeps it RAM-mappable.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];
        end else begin : g_std
            logic [DW-1:0] rd_data_q;
            always_ff @(posedge clk) begin
                if (rst)         rd_data_q <= '0;
                else if (rd_acc) rd_data_q <= mem[rd_ptr_q[AW-1:0]];
            end
            assign rd_data = rd_data_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifosync.sv
// Directed bench for fifosync: one standard-read and one FWFT instance share
// the same stimulus; a vector table covers the standard instance.
module tb_fifosync;
    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en;
    logic [DW-1:0] wr_data;

    logic          full0, af0, empty0, ae0, ovf0, unf0;
    logic [DW-1:0] rd0;
    logic [AW:0]   cnt0;
    logic          full1, af1, empty1, ae1, ovf1, unf1;
    logic [DW-1:0] rd1;
    logic [AW:0]   cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifosync #(.DW(DW), .AW(AW), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b0)) dut0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full0), .almost_full(af0), .rd_en(rd_en), .rd_data(rd0),
        .empty(empty0), .almost_empty(ae0), .count(cnt0),
        .overflow(ovf0), .underflow(unf0));

    fifosync #(.DW(DW), .AW(AW), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1'b1)) dut1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full1), .almost_full(af1), .rd_en(rd_en), .rd_data(rd1),
        .empty(empty1), .almost_empty(ae1), .count(cnt1),
        .overflow(ovf1), .underflow(unf1));

    typedef struct {
        logic          rst, wr, rd;
        logic [DW-1:0] wd;
        logic [AW:0]   cnt;
        logic          full, empty, af, ae;
        logic [DW-1:0] rdd;
        logic          ovf, unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic w, logic d, logic [DW-1:0] wd,
                                logic [AW:0] c, logic f, logic e, logic a_f, logic a_e,
                                logic [DW-1:0] rdd, logic o, logic u);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = d; v.wd = wd; v.cnt = c; v.full = f; v.empty = e;
        v.af = a_f; v.ae = a_e; v.rdd = rdd; v.ovf = o; v.unf = u;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic w, input logic d, input logic [DW-1:0] wd);
        @(negedge clk);
        rst = r; wr_en = w; rd_en = d; wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;

        //             rst wr rd data   cnt fu em af ae rdata  ov un
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h11, 1, 0, 0, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h22, 2, 0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h33, 3, 0, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h44, 4, 1, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h55, 4, 1, 0, 1, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 3, 0, 0, 1, 0, 8'h11, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 8'h22, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 8'h33, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h44, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h44, 1, 1));
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 0, 0));
        // Simultaneous traffic at count 2; pointers wrap past DEPTH.
        tbl.push_back(mk(0, 1, 0, 8'h01, 1, 0, 0, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h02, 2, 0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA0, 2, 0, 0, 0, 0, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA1, 2, 0, 0, 0, 0, 8'h02, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA2, 2, 0, 0, 0, 0, 8'hA0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA3, 2, 0, 0, 0, 0, 8'hA1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA4, 2, 0, 0, 0, 0, 8'hA2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hA5, 2, 0, 0, 0, 0, 8'hA3, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 8'hA4, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'hA5, 0, 0));
        // Full + wr/rd: only the read is taken. Empty + wr/rd: only the write.
        tbl.push_back(mk(0, 1, 0, 8'hB0, 1, 0, 0, 0, 1, 8'hA5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hB1, 2, 0, 0, 0, 0, 8'hA5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hB2, 3, 0, 0, 1, 0, 8'hA5, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'hB3, 4, 1, 0, 1, 0, 8'hA5, 0, 0));
        tbl.push_back(mk(0, 1, 1, 8'hB4, 3, 0, 0, 1, 0, 8'hB0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 2, 0, 0, 0, 0, 8'hB1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 0, 1, 8'hB2, 1, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'hB3, 1, 0));
        tbl.push_back(mk(0, 1, 1, 8'hC0, 1, 0, 0, 0, 1, 8'hB3, 1, 1));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'hC0, 1, 1));
        // Reset mid-traffic at count 3, then fresh data must come back.
        tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 1, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h71, 1, 0, 0, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h72, 2, 0, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h73, 3, 0, 0, 1, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 1, 1, 8'h99, 0, 0, 1, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 8'h77, 1, 0, 0, 0, 1, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 1, 8'h00, 0, 0, 1, 0, 1, 8'h77, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].wd);
            check($sformatf("v%0d count", i),        32'(cnt0),  32'(tbl[i].cnt));
            check($sformatf("v%0d full", i),         32'(full0), 32'(tbl[i].full));
            check($sformatf("v%0d empty", i),        32'(empty0), 32'(tbl[i].empty));
            check($sformatf("v%0d almost_full", i),  32'(af0),   32'(tbl[i].af));
            check($sformatf("v%0d almost_empty", i), 32'(ae0),   32'(tbl[i].ae));
            check($sformatf("v%0d rd_data", i),      32'(rd0),   32'(tbl[i].rdd));
            check($sformatf("v%0d overflow", i),     32'(ovf0),  32'(tbl[i].ovf));
            check($sformatf("v%0d underflow", i),    32'(unf0),  32'(tbl[i].unf));
            check($sformatf("v%0d fwft count", i),   32'(cnt1),  32'(tbl[i].cnt));
            check($sformatf("v%0d fwft empty", i),   32'(empty1), 32'(tbl[i].empty));
        end

        // FWFT: word visible one cycle after its write, no rd_en needed.
        drive(1, 0, 0, 8'h00);
        check("fwft reset rd_data", 32'(rd1), 32'h0);
        drive(0, 1, 0, 8'h5A);
        check("fwft 5A shown", 32'(rd1), 32'h5A);
        check("fwft 5A not empty", 32'(empty1), 32'h0);
        drive(0, 0, 0, 8'h00);
        check("fwft 5A held", 32'(rd1), 32'h5A);
        drive(0, 0, 1, 8'h00);
        check("fwft pop empty", 32'(empty1), 32'h1);
        check("fwft pop rd_data zero", 32'(rd1), 32'h0);
        check("std pop rd_data", 32'(rd0), 32'h5A);
        drive(0, 1, 0, 8'h01);
        check("fwft first 01", 32'(rd1), 32'h01);
        drive(0, 1, 0, 8'h02);
        check("fwft head still 01", 32'(rd1), 32'h01);
        check("fwft count 2", 32'(cnt1), 32'h2);
        drive(0, 0, 1, 8'h00);
        check("fwft then 02", 32'(rd1), 32'h02);
        drive(0, 0, 1, 8'h00);
        check("fwft drained rd_data", 32'(rd1), 32'h0);
        check("fwft drained empty", 32'(empty1), 32'h1);
        check("fwft no underflow", 32'(unf1), 32'h0);

        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
